// File: rtl/vga_pixel_fetch_pkg.sv
// Shared types and constants for the VGA pixel fetch pipeline.
// Palette geometry and per-sample sync/active flags travel in one struct.
package vga_pixel_fetch_pkg;

    localparam int unsigned PAL_DEPTH    = 16;
    localparam int unsigned PAL_IDX_BITS = 4;

    typedef struct packed {
        logic h_sync;
        logic v_sync;
        logic active;
        logic first;
    } sync_flags_t;

endpackage

// File: rtl/vga_pixel_fetch_palette.sv
// 16-entry writable colour palette with registered read.
// Asynchronous reset restores the grey ramp (entry i = {i,i,i}).
module vga_pixel_fetch_palette
    import vga_pixel_fetch_pkg::*;
#(
    parameter int unsigned COLOR_BITS = 4
) (
    input  logic                      pixel_clock,
    input  logic                      reset,
    input  logic                      we,
    input  logic [PAL_IDX_BITS-1:0]   wr_idx,
    input  logic [3*COLOR_BITS-1:0]   wr_rgb,
    input  logic [PAL_IDX_BITS-1:0]   rd_idx,
    output logic [3*COLOR_BITS-1:0]   rd_rgb
);

    logic [3*COLOR_BITS-1:0] entries [PAL_DEPTH];

    // Read samples the array before this edge's write lands, so a same-cycle
    // write to the index being read returns the previous entry.
    always_ff @(posedge pixel_clock or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < PAL_DEPTH; i++) begin
                entries[i] <= {3{COLOR_BITS'(i)}};
            end
            rd_rgb <= '0;
        end else begin
            rd_rgb <= entries[rd_idx];
            if (we) begin
                entries[wr_idx] <= wr_rgb;
            end
        end
    end

endmodule

// File: rtl/vga_pixel_fetch.sv
// Fetches palette indices from a synchronous framebuffer with integer down-scaling,
// maps them through the palette and keeps sync aligned with colour (4-cycle latency).
module vga_pixel_fetch
    import vga_pixel_fetch_pkg::*;
#(
    parameter int unsigned H_POS_SIZE  = 9,
    parameter int unsigned V_POS_SIZE  = 9,
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned SCALE_SHIFT = 1,
    parameter int unsigned ADDR_WIDTH  = 17,
    parameter int unsigned COLOR_BITS  = 4
) (
    input  logic                    pixel_clock,
    input  logic                    reset,
    input  logic                    h_sync_in,
    input  logic                    v_sync_in,
    input  logic [H_POS_SIZE:0]     h_pos,
    input  logic [V_POS_SIZE:0]     v_pos,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic                    mem_rd,
    input  logic [PAL_IDX_BITS-1:0] mem_data,
    input  logic                    pal_we,
    input  logic [PAL_IDX_BITS-1:0] pal_idx,
    input  logic [3*COLOR_BITS-1:0] pal_rgb,
    output logic                    VGA_HS,
    output logic                    VGA_VS,
    output logic [COLOR_BITS-1:0]   VGA_R,
    output logic [COLOR_BITS-1:0]   VGA_G,
    output logic [COLOR_BITS-1:0]   VGA_B,
    output logic                    frame_start
);

    sync_flags_t               flags_in;
    sync_flags_t               s0, s1, s2, s3;
    logic [H_POS_SIZE:0]       h_q;
    logic [V_POS_SIZE:0]       v_q;
    logic [3*COLOR_BITS-1:0]   pal_q;

    always_comb begin
        flags_in        = '0;
        flags_in.h_sync = h_sync_in;
        flags_in.v_sync = v_sync_in;
        flags_in.active = (h_pos != '1) && (v_pos != '1)
                       && (32'(h_pos) < H_ACTIVE) && (32'(v_pos) < V_ACTIVE);
        flags_in.first  = (h_pos == '0) && (v_pos == '0);
    end

    // s0..s3 run in parallel with address issue, RAM access and palette lookup;
    // s3 lines up with the palette's registered output.
    always_ff @(posedge pixel_clock or negedge reset) begin
        if (!reset) begin
            s0       <= '0;
            s1       <= '0;
            s2       <= '0;
            s3       <= '0;
            h_q      <= '0;
            v_q      <= '0;
            mem_addr <= '0;
            mem_rd   <= 1'b0;
        end else begin
            s0     <= flags_in;
            h_q    <= h_pos;
            v_q    <= v_pos;
            s1     <= s0;
            s2     <= s1;
            s3     <= s2;
            mem_rd <= s0.active;
            if (s0.active) begin
                mem_addr <= ADDR_WIDTH'(ADDR_WIDTH'(v_q >> SCALE_SHIFT)
                                        * ADDR_WIDTH'(H_ACTIVE >> SCALE_SHIFT)
                                        + ADDR_WIDTH'(h_q >> SCALE_SHIFT));
            end
        end
    end

    vga_pixel_fetch_palette #(
        .COLOR_BITS (COLOR_BITS)
    ) u_palette (
        .pixel_clock (pixel_clock),
        .reset       (reset),
        .we          (pal_we),
        .wr_idx      (pal_idx),
        .wr_rgb      (pal_rgb),
        .rd_idx      (mem_data),
        .rd_rgb      (pal_q)
    );

    assign VGA_HS      = s3.h_sync;
    assign VGA_VS      = s3.v_sync;
    assign frame_start = s3.first;
    assign {VGA_R, VGA_G, VGA_B} = s3.active ? pal_q : '0;

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Self-checking bench for vga_pixel_fetch against a queue-based sample-history model.
module tb_vga_pixel_fetch;

    logic        pixel_clock = 1'b0;
    logic        reset       = 1'b0;
    logic        h_sync_in   = 1'b1;
    logic        v_sync_in   = 1'b1;
    logic [9:0]  h_pos       = '1;
    logic [9:0]  v_pos       = '1;
    logic [16:0] mem_addr;
    logic        mem_rd;
    logic [3:0]  mem_data    = '0;
    logic        pal_we      = 1'b0;
    logic [3:0]  pal_idx     = '0;
    logic [11:0] pal_rgb     = '0;
    logic        VGA_HS, VGA_VS, frame_start;
    logic [3:0]  VGA_R, VGA_G, VGA_B;

    vga_pixel_fetch #(
        .H_POS_SIZE (9), .V_POS_SIZE (9), .H_ACTIVE (640), .V_ACTIVE (480),
        .SCALE_SHIFT (1), .ADDR_WIDTH (17), .COLOR_BITS (4)
    ) dut (
        .pixel_clock (pixel_clock), .reset (reset),
        .h_sync_in (h_sync_in), .v_sync_in (v_sync_in),
        .h_pos (h_pos), .v_pos (v_pos),
        .mem_addr (mem_addr), .mem_rd (mem_rd), .mem_data (mem_data),
        .pal_we (pal_we), .pal_idx (pal_idx), .pal_rgb (pal_rgb),
        .VGA_HS (VGA_HS), .VGA_VS (VGA_VS),
        .VGA_R (VGA_R), .VGA_G (VGA_G), .VGA_B (VGA_B),
        .frame_start (frame_start)
    );

    always #5 pixel_clock = ~pixel_clock;

    // Synchronous framebuffer: data valid one cycle after the address.
    logic [3:0] ram [0:131071];
    always @(posedge pixel_clock) mem_data <= ram[mem_addr];

    typedef struct {
        int h;
        int v;
        bit hs;
        bit vs;
        bit act;
        bit first;
    } smp_t;

    smp_t        hist[$];
    logic [11:0] pal_m [16];
    logic [16:0] exp_addr;
    logic        exp_rd;
    logic [32:0] exp_bus;
    wire  [32:0] obs = {mem_rd, mem_addr, VGA_HS, VGA_VS, frame_start, VGA_R, VGA_G, VGA_B};
    int          errors = 0;
    int          checks = 0;
    int          rd_cnt [131072];
    int          fs_cnt = 0;

    function automatic int fb_addr(input int h, input int v);
        return (v / 2) * 320 + (h / 2);
    endfunction

    function automatic bit is_act(input int h, input int v);
        return (h < 640) && (v < 480);
    endfunction

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < 16; i++) pal_m[i] = {3{4'(i)}};
        exp_addr = '0;
        exp_rd   = 1'b0;
        exp_bus  = '0;
    endtask

    task automatic drive(input int h, input int v, input bit hs, input bit vs);
        h_pos     = 10'(h);
        v_pos     = 10'(v);
        h_sync_in = hs;
        v_sync_in = vs;
    endtask

    // One clock: model the edge, then settle 1 time unit past it.
    task automatic cycle();
        smp_t        s;
        logic [11:0] rgb;
        bit          hs, vs, fs;
        @(posedge pixel_clock);
        if (!reset) begin
            model_reset();
        end else begin
            s.h = int'(h_pos);
            s.v = int'(v_pos);
            s.hs = h_sync_in;
            s.vs = v_sync_in;
            s.act = is_act(s.h, s.v);
            s.first = (s.h == 0) && (s.v == 0);
            hist.push_front(s);
            if (hist.size() > 4) void'(hist.pop_back());
            exp_rd = 1'b0;
            if (hist.size() > 1 && hist[1].act) begin
                exp_rd   = 1'b1;
                exp_addr = 17'(fb_addr(hist[1].h, hist[1].v));
            end
            rgb = '0; hs = 0; vs = 0; fs = 0;
            if (hist.size() > 3) begin
                hs = hist[3].hs;
                vs = hist[3].vs;
                fs = hist[3].first;
                if (hist[3].act) rgb = pal_m[ram[fb_addr(hist[3].h, hist[3].v)]];
            end
            if (pal_we) pal_m[pal_idx] = pal_rgb;
            exp_bus = {exp_rd, exp_addr, hs, vs, fs, rgb};
        end
        #1;
        if (mem_rd === 1'b1) rd_cnt[mem_addr]++;
        if (frame_start === 1'b1) fs_cnt++;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        model_reset();
        repeat (3) cycle();
        checks++;
        if (obs !== 33'h0) begin
            errors++; $display("FAIL reset_state got=%h want=%h", obs, 33'h0);
        end
        @(negedge pixel_clock);
        reset = 1'b1;
    endtask

    task automatic test_first_pixel();
        for (int c = 1; c <= 6; c++) begin
            if (c == 1) drive(0, 0, 1, 1); else drive(1023, 0, 1, 1);
            cycle();
            checks++;
            if (obs !== exp_bus) begin
                errors++; $display("FAIL first_pixel c=%0d got=%h want=%h", c, obs, exp_bus);
            end
            if (c == 2) begin
                checks++;
                if (mem_rd !== 1'b1 || mem_addr !== 17'd0) begin
                    errors++; $display("FAIL first_addr rd=%b addr=%0d want rd=1 addr=0", mem_rd, mem_addr);
                end
            end
            if (c == 4) begin
                checks++;
                if (frame_start !== 1'b1) begin
                    errors++; $display("FAIL frame_start got=%b want=1", frame_start);
                end
            end
        end
    endtask

    task automatic test_scaled_addr();
        ram[322] = 4'hA;
        ram[76799] = 4'h7;
        for (int c = 1; c <= 10; c++) begin
            if (c == 1) drive(5, 3, 1, 1);
            else if (c == 5) drive(639, 479, 1, 1);
            else drive(1023, 1023, 1, 1);
            cycle();
            checks++;
            if (obs !== exp_bus) begin
                errors++; $display("FAIL scaled_addr c=%0d got=%h want=%h", c, obs, exp_bus);
            end
            if (c == 2 || c == 6) begin
                checks++;
                if (mem_addr !== ((c == 2) ? 17'd322 : 17'd76799)) begin
                    errors++; $display("FAIL addr_value c=%0d got=%0d", c, mem_addr);
                end
            end
            if (c == 4 || c == 8) begin
                checks++;
                if ({VGA_R, VGA_G, VGA_B} !== ((c == 4) ? 12'hAAA : 12'h777)) begin
                    errors++; $display("FAIL pixel_rgb c=%0d got=%h", c, {VGA_R, VGA_G, VGA_B});
                end
            end
        end
    endtask

    task automatic test_blanking();
        bit hs_drv [1:40];
        for (int c = 1; c <= 40; c++) begin
            hs_drv[c] = 1'($urandom_range(0, 1));
            drive(1023, $urandom_range(0, 479), hs_drv[c], 1);
            cycle();
            checks++;
            if (obs !== exp_bus) begin
                errors++; $display("FAIL blanking c=%0d got=%h want=%h", c, obs, exp_bus);
            end
            if (c >= 4) begin
                checks++;
                if (VGA_HS !== hs_drv[c-3] || mem_rd !== 1'b0 || {VGA_R, VGA_G, VGA_B} !== 12'h0) begin
                    errors++;
                    $display("FAIL hs_delay c=%0d hs=%b want=%b rd=%b rgb=%h", c, VGA_HS, hs_drv[c-3], mem_rd, {VGA_R, VGA_G, VGA_B});
                end
            end
        end
    endtask

    task automatic test_palette_write();
        ram[fb_addr(10, 10)] = 4'd3;
        ram[fb_addr(12, 10)] = 4'd3;
        for (int c = 1; c <= 10; c++) begin
            if (c == 1) drive(10, 10, 1, 1);
            else if (c == 5) drive(12, 10, 1, 1);
            else drive(1023, 10, 1, 1);
            pal_we  = (c == 4);
            pal_idx = 4'd3;
            pal_rgb = 12'hF00;
            cycle();
            checks++;
            if (obs !== exp_bus) begin
                errors++; $display("FAIL palette c=%0d got=%h want=%h", c, obs, exp_bus);
            end
            if (c == 4 || c == 8) begin
                checks++;
                if ({VGA_R, VGA_G, VGA_B} !== ((c == 4) ? 12'h333 : 12'hF00)) begin
                    errors++; $display("FAIL pal_same_cycle c=%0d got=%h", c, {VGA_R, VGA_G, VGA_B});
                end
            end
        end
        pal_we = 1'b0;
    endtask

    task automatic test_random();
        int r, h, v;
        for (int i = 0; i < 131072; i++) ram[i] = 4'($urandom);
        for (int c = 1; c <= 400; c++) begin
            r = $urandom_range(0, 9);
            h = (r < 6) ? $urandom_range(0, 639) : (r < 8) ? $urandom_range(640, 1022) : 1023;
            r = $urandom_range(0, 9);
            v = (r < 6) ? $urandom_range(0, 479) : (r < 8) ? $urandom_range(480, 1022) : 1023;
            drive(h, v, 1'($urandom), 1'($urandom));
            pal_we  = ($urandom_range(0, 3) == 0);
            pal_idx = 4'($urandom);
            pal_rgb = 12'($urandom);
            cycle();
            checks++;
            if (obs !== exp_bus) begin
                errors++; $display("FAIL random c=%0d got=%h want=%h", c, obs, exp_bus);
            end
        end
        pal_we = 1'b0;
        drive(1023, 1023, 1, 1);
        repeat (4) cycle();
    endtask

    task automatic run_line(input int line, input int pixels);
        for (int x = 0; x < pixels; x++) begin
            drive((x < 640) ? x : 1023, (line < 480) ? line : 1023,
                  !(x >= 656 && x < 752), !(line == 490 || line == 491));
            cycle();
            checks++;
            if (obs !== exp_bus) begin
                errors++; $display("FAIL frame line=%0d x=%0d got=%h want=%h", line, x, obs, exp_bus);
            end
        end
    endtask

    task automatic test_frame();
        int lines[$];
        int bad, total;
        for (int i = 0; i < 131072; i++) begin
            ram[i]    = 4'(i ^ (i >> 7));
            rd_cnt[i] = 0;
        end
        fs_cnt = 0;
        for (int l = 0; l < 20; l++) lines.push_back(l);
        lines.push_back(478); lines.push_back(479); lines.push_back(480);
        lines.push_back(490); lines.push_back(491); lines.push_back(524);
        foreach (lines[i]) run_line(lines[i], 800);
        bad = 0; total = 0;
        for (int a = 0; a < 131072; a++) total += rd_cnt[a];
        for (int row = 0; row < 240; row++) begin
            if (row < 10 || row == 239) begin
                for (int col = 0; col < 320; col++) if (rd_cnt[row*320 + col] != 4) bad++;
            end
        end
        checks++;
        if (bad != 0 || total != 640 * 22) begin
            errors++; $display("FAIL read_counts bad_entries=%0d total=%0d want 0 and %0d", bad, total, 640 * 22);
        end
        checks++;
        if (fs_cnt != 1) begin
            errors++; $display("FAIL frame_start_count got=%0d want=1", fs_cnt);
        end
        run_line(0, 800);
        checks++;
        if (fs_cnt != 2) begin
            errors++; $display("FAIL frame_start_next got=%0d want=2", fs_cnt);
        end
    endtask

    task automatic test_reset_mid_line();
        for (int i = 0; i < 16; i++) begin
            pal_we = 1'b1; pal_idx = 4'(i); pal_rgb = 12'($urandom);
            drive(1023, 1023, 1, 1);
            cycle();
        end
        pal_we = 1'b0;
        for (int x = 0; x < 20; x++) begin
            drive(x, 100, 1, 1);
            cycle();
            checks++;
            if (obs !== exp_bus) begin
                errors++; $display("FAIL pre_reset x=%0d got=%h want=%h", x, obs, exp_bus);
            end
        end
        #2 reset = 1'b0;
        #1;
        model_reset();
        checks++;
        if (obs !== 33'h0) begin
            errors++; $display("FAIL async_reset got=%h want=%h", obs, 33'h0);
        end
        repeat (2) cycle();
        @(negedge pixel_clock);
        reset = 1'b1;
        ram[fb_addr(2, 0)] = 4'h5;
        for (int c = 1; c <= 8; c++) begin
            if (c == 1) drive(2, 0, 0, 1); else drive(1023, 0, 1, 1);
            cycle();
            checks++;
            if (obs !== exp_bus) begin
                errors++; $display("FAIL post_reset c=%0d got=%h want=%h", c, obs, exp_bus);
            end
            if (c == 4) begin
                checks++;
                if ({VGA_R, VGA_G, VGA_B} !== 12'h555 || VGA_HS !== 1'b0) begin
                    errors++; $display("FAIL grey_after_reset rgb=%h hs=%b want 555 0", {VGA_R, VGA_G, VGA_B}, VGA_HS);
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 131072; i++) begin
            ram[i]    = '0;
            rd_cnt[i] = 0;
        end
        test_reset();
        test_first_pixel();
        test_scaled_addr();
        test_blanking();
        test_palette_write();
        test_random();
        test_frame();
        test_reset_mid_line();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
